// File: rtl/ro_meas_pkg.sv
// ============================================================================
// Module  : ro_meas_pkg
// Brief   : Shared state encodings, default widths and ID-width helper for
//           the ring-oscillator measurement controller.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package ro_meas_pkg;

    localparam int DEF_NUM_RO     = 4;
    localparam int DEF_CNT_W      = 16;
    localparam int DEF_WIN_W      = 16;
    localparam int DEF_SETTLE_CYC = 4;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_SETTLE  = 2'd1;
    localparam logic [1:0] ST_MEASURE = 2'd2;
    localparam logic [1:0] ST_STORE   = 2'd3;

    // A single oscillator still needs a 1-bit index field.
    function automatic int id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ro_edge_counter.sv
// ============================================================================
// Module  : ro_edge_counter
// Brief   : 2-FF synchroniser, rising-edge detect and saturating edge counter
//           for one (muxed) divided ring-oscillator output.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module ro_edge_counter
    import ro_meas_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tog,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] count,
    output logic             sat
);

    logic [2:0]       r_sync;
    logic [CNT_W-1:0] r_cnt;
    logic             w_rise;

    assign w_rise = r_sync[1] & ~r_sync[2];

    // count/sat include an edge detected in the current cycle, so the
    // controller can capture the final value on the window's last cycle.
    always_comb begin
        count = r_cnt;
        if (en && w_rise && !(&r_cnt)) begin
            count = r_cnt + CNT_W'(1);
        end
    end

    assign sat = &count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= '0;
            r_cnt  <= '0;
        end else begin
            r_sync <= {r_sync[1:0], tog};
            r_cnt  <= clr ? '0 : count;
        end
    end

endmodule

`default_nettype wire

// File: rtl/ro_meas_ctrl.sv
// ============================================================================
// Module  : ro_meas_ctrl
// Brief   : Scans a bank of ring oscillators one at a time (settle, measure
//           window, store) and reports an edge count per oscillator.
//           Optional macro RO_MEAS_CONT_EN adds the cont input for
//           continuous wrap-around scanning.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module ro_meas_ctrl
    import ro_meas_pkg::*;
#(
    parameter int NUM_RO     = DEF_NUM_RO,
    parameter int CNT_W      = DEF_CNT_W,
    parameter int WIN_W      = DEF_WIN_W,
    parameter int SETTLE_CYC = DEF_SETTLE_CYC
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      abort,
`ifdef RO_MEAS_CONT_EN
    input  logic                      cont,
`endif
    input  logic [NUM_RO-1:0]         scan_mask,
    input  logic [WIN_W-1:0]          win_len,
    input  logic [NUM_RO-1:0]         ro_tog,
    output logic [NUM_RO-1:0]         ro_en,
    output logic                      busy,
    output logic                      meas_valid,
    output logic [id_w(NUM_RO)-1:0]   meas_id,
    output logic [CNT_W-1:0]          meas_count,
    output logic                      meas_sat,
    output logic                      scan_done
);

    localparam int ID_W = id_w(NUM_RO);

    logic [1:0]        r_state;
    logic [NUM_RO-1:0] r_mask;
    logic [WIN_W-1:0]  r_win;
    logic [WIN_W-1:0]  r_timer;
    logic [ID_W-1:0]   r_sel;

    logic [ID_W-1:0]   w_first_in;
    logic [ID_W-1:0]   w_first_mask;
    logic [ID_W-1:0]   w_next;
    logic              w_has_next;
    logic              w_cont;
    logic              w_tog;
    logic              w_last_settle;
    logic              w_last_win;
    logic [CNT_W-1:0]  w_count;
    logic              w_sat;

`ifdef RO_MEAS_CONT_EN
    assign w_cont = cont;
`else
    assign w_cont = 1'b0;
`endif

    // Descending loops leave the lowest qualifying index as the result.
    always_comb begin
        w_first_in   = '0;
        w_first_mask = '0;
        w_next       = '0;
        w_has_next   = 1'b0;
        for (int i = NUM_RO - 1; i >= 0; i--) begin
            if (scan_mask[i]) begin
                w_first_in = ID_W'(i);
            end
            if (r_mask[i]) begin
                w_first_mask = ID_W'(i);
            end
            if (r_mask[i] && (i > int'(r_sel))) begin
                w_next     = ID_W'(i);
                w_has_next = 1'b1;
            end
        end
    end

    // Enable decoded straight from state flops so an async reset drops it at once.
    always_comb begin
        ro_en = '0;
        if ((r_state == ST_SETTLE) || (r_state == ST_MEASURE)) begin
            ro_en[r_sel] = 1'b1;
        end
    end

    assign busy          = (r_state != ST_IDLE);
    assign w_tog         = ro_tog[r_sel];
    assign w_last_settle = (r_timer == WIN_W'(SETTLE_CYC - 1));
    assign w_last_win    = (r_timer == (r_win - WIN_W'(1)));

    ro_edge_counter #(
        .CNT_W (CNT_W)
    ) u_edge_counter (
        .clk   (clk),
        .rst   (rst),
        .tog   (w_tog),
        .clr   (r_state != ST_MEASURE),
        .en    (r_state == ST_MEASURE),
        .count (w_count),
        .sat   (w_sat)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_mask     <= '0;
            r_win      <= '0;
            r_timer    <= '0;
            r_sel      <= '0;
            meas_valid <= 1'b0;
            meas_id    <= '0;
            meas_count <= '0;
            meas_sat   <= 1'b0;
            scan_done  <= 1'b0;
        end else begin
            meas_valid <= 1'b0;
            scan_done  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start && !abort) begin
                        if (|scan_mask) begin
                            r_mask  <= scan_mask;
                            r_win   <= (win_len == '0) ? WIN_W'(1) : win_len;
                            r_sel   <= w_first_in;
                            r_timer <= '0;
                            r_state <= ST_SETTLE;
                        end else begin
                            scan_done <= 1'b1;
                        end
                    end
                end
                ST_SETTLE: begin
                    if (abort) begin
                        r_state <= ST_IDLE;
                    end else if (w_last_settle) begin
                        r_timer <= '0;
                        r_state <= ST_MEASURE;
                    end else begin
                        r_timer <= r_timer + WIN_W'(1);
                    end
                end
                ST_MEASURE: begin
                    if (abort) begin
                        r_state <= ST_IDLE;
                    end else if (w_last_win) begin
                        meas_valid <= 1'b1;
                        meas_id    <= r_sel;
                        meas_count <= w_count;
                        meas_sat   <= w_sat;
                        r_timer    <= '0;
                        r_state    <= ST_STORE;
                    end else begin
                        r_timer <= r_timer + WIN_W'(1);
                    end
                end
                ST_STORE: begin
                    r_timer <= '0;
                    if (abort) begin
                        r_state <= ST_IDLE;
                    end else if (w_has_next) begin
                        r_sel   <= w_next;
                        r_state <= ST_SETTLE;
                    end else begin
                        scan_done <= 1'b1;
                        if (w_cont) begin
                            r_sel   <= w_first_mask;
                            r_state <= ST_SETTLE;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: doc/ro_meas_ctrl.md
Name: ro_meas_ctrl

Overview:
Sequencer for a bank of NAND-based ring oscillators (reliability/aging sensors).
- Enables one oscillator at a time, waits a settle period, then counts rising edges of that oscillator's divided toggle output over a programmable window of clk cycles.
- Reports each count with its oscillator index.
- Sits between the RO bank and the AXI register interface of the sensor IP.

Parameters:
- NUM_RO, 4, number of oscillators scanned (1..16).
- CNT_W, 16, edge-count width.
- WIN_W, 16, window-length register width.
- SETTLE_CYC, 4, clk cycles between RO enable and count start (≥3, so the synchroniser is flushed).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a scan when idle.
- abort  in  1  one-cycle pulse; terminates the scan.
- scan_mask  in  NUM_RO  oscillators to visit; sampled on start.
- win_len  in  WIN_W  measurement window in clk cycles; sampled on start.
- ro_tog  in  NUM_RO  divided RO outputs; asynchronous to clk.
- ro_en  out  NUM_RO  one-hot oscillator enable.
- busy  out  1  scan in progress.
- meas_valid  out  1  one-cycle pulse; result fields valid.
- meas_id  out  $clog2(NUM_RO)  index of the oscillator measured.
- meas_count  out  CNT_W  edge count.
- meas_sat  out  1  count saturated.
- scan_done  out  1  one-cycle pulse at end of a full scan.

Behaviour:
- Reset (async, immediate): all outputs 0; state IDLE; latched mask/window cleared. Reset mid-scan kills ro_en in the same instant, without waiting for clk.
- States: IDLE, SETTLE, MEASURE, STORE.
- IDLE:
  - start=1 with scan_mask≠0 → latch mask and window (win_len=0 treated as 1); select the lowest set bit; go to SETTLE.
  - start with scan_mask=0 → scan_done pulses the next cycle; no ro_en, no meas_valid.
- SETTLE:
  - ro_en one-hot at the selected index, from the cycle after the start cycle.
  - Counter held at 0; lasts SETTLE_CYC cycles, then MEASURE.
- MEASURE:
  - Lasts exactly win_len cycles; ro_en held.
  - ro_tog[sel] passes through a 2-FF synchroniser and a rising-edge detector; each detected edge adds 1.
  - The counter saturates at all-ones and sets sat.
  - Edges within the last 2 cycles of the window are lost to synchroniser latency. This is accepted and documented; bias is constant across oscillators.
- STORE (1 cycle):
  - ro_en=0; meas_valid=1; meas_id=sel; meas_count and meas_sat registered.
  - Next cycle: go to SETTLE at the next higher set bit of the latched mask. If none remain, go to IDLE and pulse scan_done.
- busy=1 in every state except IDLE. meas_* fields hold their value until the next STORE.
- start while busy is ignored; scan_mask/win_len changes during a scan have no effect.
- abort in SETTLE/MEASURE/STORE → IDLE next cycle; ro_en=0. No meas_valid for the aborted RO (an abort arriving in STORE still lets that cycle's valid through); no scan_done.
- abort and start in the same IDLE cycle: abort wins, scan not started.
- Oscillator switch always passes through STORE (ro_en=0 for ≥1 cycle) — never two enables high at once.

Optional Feature:
Macro RO_MEAS_CONT_EN.
- Defined: adds input cont (1 bit). When cont=1 at the end of a scan, scan_done still pulses and the controller wraps to the lowest set mask bit (SETTLE) instead of IDLE; busy stays 1. Clearing cont lets the current scan finish normally. abort still terminates.
- Undefined: no cont port; every scan ends in IDLE.

Decomposition:
- Package ro_meas_pkg: state enum (IDLE, SETTLE, MEASURE, STORE), ID_W = $clog2(NUM_RO) helper, default width constants.
- Sub-module ro_edge_counter: 2-FF synchroniser, edge detect, clear/enable, saturating CNT_W counter with sat flag. Instanced once, fed by an NUM_RO:1 mux of ro_tog on sel.

Test Plan:
- Mask 4'b0101, win_len=100, ro_tog[0] period 10 clk, ro_tog[2] period 20 clk, SETTLE_CYC=4 → valid id0 count 9–10, then id2 count 4–5; scan_done once; ro_en never multi-hot.
- CNT_W=4, win_len=200, ro_tog period 4 → meas_count=15, meas_sat=1.
- start with scan_mask=0 → scan_done 1 cycle later, busy stays 0, no meas_valid.
- abort mid-MEASURE on id1 → ro_en=0 next cycle, no meas_valid, no scan_done; a subsequent start is accepted.
- Assert rst mid-MEASURE → ro_en and busy drop without a clk edge; after release, a start scans normally.
- RO_MEAS_CONT_EN defined, cont=1, mask 4'b0011 → id0, id1, scan_done, id0, id1 … repeats; clearing cont ends after the current id1.
